// File: rtl/izh_neuron_array_if.sv
// Host-side bus of the Izhikevich neuron array: sweep handshake, current feed,
// configuration writes and the v probe.
interface izh_neuron_array_if #(
    parameter int N_NEURONS = 4,
    parameter int W         = 18
);
    localparam int IDW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                 step_start;
    logic                 busy;
    logic                 step_done;
    logic [IDW-1:0]       cur_id;
    logic [W-1:0]         cur_in;
    logic [N_NEURONS-1:0] spike_vec;
    logic                 cfg_we;
    logic [IDW-1:0]       cfg_addr;
    logic [1:0]           cfg_sel;
    logic [W-1:0]         cfg_data;
    logic [IDW-1:0]       probe_id;
    logic [W-1:0]         probe_v;

    modport master (
        output step_start, cur_in, cfg_we, cfg_addr, cfg_sel, cfg_data, probe_id,
        input  busy, step_done, cur_id, spike_vec, probe_v
    );

    modport slave (
        input  step_start, cur_in, cfg_we, cfg_addr, cfg_sel, cfg_data, probe_id,
        output busy, step_done, cur_id, spike_vec, probe_v
    );
endinterface

// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of Izhikevich neurons: one shared saturating Q2.(W-2)
// datapath updates one neuron per cycle during a sweep.
module izh_neuron_array #(
    parameter int           N_NEURONS = 4,
    parameter int           W         = 18,
    parameter logic [W-1:0] VPEAK     = 18'h04CCC,
    parameter logic [W-1:0] V_INIT    = 18'h34CCD,
    parameter logic [W-1:0] U_INIT    = 18'h3CCCD,
    parameter logic [W-1:0] C_DEF     = 18'h34CCD,
    parameter logic [W-1:0] D_DEF     = 18'h04CCD,
    parameter logic [W-1:0] K14       = 18'h16666
) (
    input logic              clk,
    input logic              rst,
    izh_neuron_array_if.slave bus
);
    localparam int IDW  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int FRAC = W - 2;
    localparam int XW   = W + 3;
    localparam logic [IDW-1:0] LAST = IDW'(N_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t               state, state_nxt;
    logic [IDW-1:0]       idx;
    logic [N_NEURONS-1:0] spike_acc, spike_merge, spike_q;
    logic [W-1:0]         probe_q;
    logic                 busy, step_done;

    logic signed [W-1:0] v_mem [N_NEURONS];
    logic signed [W-1:0] u_mem [N_NEURONS];
    logic signed [W-1:0] c_mem [N_NEURONS];
    logic signed [W-1:0] d_mem [N_NEURONS];
    logic        [3:0]   a_mem [N_NEURONS];
    logic        [3:0]   b_mem [N_NEURONS];

    function automatic logic signed [XW-1:0] ext(input logic signed [W-1:0] x);
        return {{(XW-W){x[W-1]}}, x};
    endfunction

    // Clamp a wide intermediate back into W bits instead of wrapping.
    function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] x);
        if (&x[XW-1:W-1] || ~|x[XW-1:W-1])
            return x[W-1:0];
        else if (x[XW-1])
            return {1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, {(W-1){1'b1}}};
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
        state_nxt = state;
        busy      = 1'b0;
        step_done = 1'b0;
        case (state)
            IDLE:  if (bus.step_start) state_nxt = SWEEP;
            SWEEP: begin
                busy = 1'b1;
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                step_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    logic signed [W-1:0]   v_cur, u_cur, c_cur, d_cur, i_cur, vv;
    logic        [3:0]     a_cur, b_cur;
    logic signed [2*W-1:0] v_wide, prod;
    logic signed [XW-1:0]  dv_sum, du_diff;
    logic signed [W-1:0]   v_upd, u_upd, u_spk, v_next, u_next;
    logic                  spike_now;
    logic                  unused_prod_bits;

    always_comb begin
        v_cur  = v_mem[idx];
        u_cur  = u_mem[idx];
        c_cur  = c_mem[idx];
        d_cur  = d_mem[idx];
        a_cur  = a_mem[idx];
        b_cur  = b_mem[idx];
        i_cur  = $signed(bus.cur_in);
        v_wide = {{W{v_cur[W-1]}}, v_cur};
        prod   = v_wide * v_wide;
        vv     = {prod[2*W-1], prod[2*W-4:FRAC]};

        dv_sum  = ext(vv) + ext(v_cur) + ext(v_cur >>> 2) + ext($signed(K14) >>> 2)
                - ext(u_cur >>> 2) + ext(i_cur >>> 2);
        v_upd   = sat(ext(v_cur) + (dv_sum >>> 2));
        du_diff = ext(v_cur >>> b_cur) - ext(u_cur);
        u_upd   = sat(ext(u_cur) + ((du_diff >>> a_cur) >>> 4));
        u_spk   = sat(ext(u_cur) + ext(d_cur));

        spike_now = v_cur > $signed(VPEAK);
        v_next    = spike_now ? c_cur : v_upd;
        u_next    = spike_now ? u_spk : u_upd;

        spike_merge      = spike_acc;
        spike_merge[idx] = spike_now;
    end

    assign unused_prod_bits = ^{prod[2*W-2:2*W-3], prod[FRAC-1:0]};

    // ----------------------------------------------------- per-neuron state
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the state arrays are flops, not RAM, so every entry takes its reset value synchronously.
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k] <= V_INIT;
                u_mem[k] <= U_INIT;
                c_mem[k] <= C_DEF;
                d_mem[k] <= D_DEF;
                a_mem[k] <= 4'd2;
                b_mem[k] <= 4'd2;
            end
        end else begin
            for (int k = 0; k < N_NEURONS; k++) begin
                if (state == SWEEP && idx == IDW'(k)) begin
                    v_mem[k] <= v_next;
                    u_mem[k] <= u_next;
                end
                // NOTE: non-blocking and issued after the update, so a cfg v write to the active neuron wins.
                if (bus.cfg_we && bus.cfg_addr == IDW'(k)) begin
                    case (bus.cfg_sel)
                        2'd0: begin
                            a_mem[k] <= bus.cfg_data[3:0];
                            b_mem[k] <= bus.cfg_data[7:4];
                        end
                        2'd1:    c_mem[k] <= bus.cfg_data;
                        2'd2:    d_mem[k] <= bus.cfg_data;
                        default: v_mem[k] <= bus.cfg_data;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------- sweep index / outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            spike_acc <= '0;
            spike_q   <= '0;
            probe_q   <= V_INIT;
        end else begin
            probe_q <= v_mem[bus.probe_id];
            case (state)
                IDLE: if (bus.step_start) begin
                    idx       <= '0;
                    spike_acc <= '0;
                end
                SWEEP: begin
                    spike_acc <= spike_merge;
                    idx       <= idx + 1'b1;
                    // The last bit is folded in here so spike_vec is already valid during DONE.
                    if (idx == LAST) begin
                        idx     <= '0;
                        spike_q <= spike_merge;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.step_done = step_done;
    assign bus.cur_id    = busy ? idx : '0;
    assign bus.spike_vec = spike_q;
    assign bus.probe_v   = probe_q;
endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed bench for izh_neuron_array: hand-computed key values plus an integer
// model of the neuron equations for the longer runs.
module tb_izh_neuron_array;
    localparam int N   = 4;
    localparam int W   = 18;
    localparam int IDW = 2;
    localparam int VPEAK_I = 19660;
    localparam int K14_I   = 91750;
    localparam int VMAX    = 131071;
    localparam int VMIN    = -131072;

    logic clk;
    logic rst;

    izh_neuron_array_if #(.N_NEURONS(N), .W(W)) bus ();
    izh_neuron_array #(.N_NEURONS(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [W-1:0] cur_tab [N];
    int mv [N], mu [N], ma [N], mb [N], mc [N], md [N];
    logic [N-1:0] exp_spk;
    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus source: supplies the current of whichever neuron the array asks for.
    always_comb bus.cur_in = cur_tab[bus.cur_id];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int s18(input logic [W-1:0] x);
        return int'($signed(x));
    endfunction

    function automatic int sat_m(input int x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    function automatic logic [W-1:0] to18(input int x);
        return x[W-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mv[k] = -45875; mu[k] = -13107; mc[k] = -45875; md[k] = 19661;
            ma[k] = 2;      mb[k] = 2;
        end
    endtask

    task automatic model_cfg(input int k, input int sel, input logic [W-1:0] data);
        case (sel)
            0: begin ma[k] = int'(data[3:0]); mb[k] = int'(data[7:4]); end
            1: mc[k] = s18(data);
            2: md[k] = s18(data);
            default: mv[k] = s18(data);
        endcase
    endtask

    task automatic model_sweep(input int mk, input int msel, input logic [W-1:0] mdata);
        int v, u, i, vv, dv, du;
        longint p;
        exp_spk = '0;
        for (int k = 0; k < N; k++) begin
            v = mv[k]; u = mu[k]; i = s18(cur_tab[k]);
            if (v > VPEAK_I) begin
                mv[k] = mc[k];
                mu[k] = sat_m(u + md[k]);
                exp_spk[k] = 1'b1;
            end else begin
                p  = longint'(v) * longint'(v);
                vv = int'((p >> 16) & 64'h1FFFF);
                dv = (vv + v + (v >>> 2) + (K14_I >>> 2) - (u >>> 2) + (i >>> 2)) >>> 2;
                du = (((v >>> mb[k]) - u) >>> ma[k]) >>> 4;
                mv[k] = sat_m(v + dv);
                mu[k] = sat_m(u + du);
            end
            if (k == mk) model_cfg(mk, msel, mdata);
        end
    endtask

    task automatic cfg_write(input int k, input int sel, input logic [W-1:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = k[IDW-1:0];
        bus.cfg_sel  = sel[1:0];
        bus.cfg_data = data;
        tick();
        bus.cfg_we = 1'b0;
        model_cfg(k, sel, data);
    endtask

    task automatic probe_chk(input string tag, input int k, input logic [W-1:0] exp);
        bus.probe_id = k[IDW-1:0];
        tick();
        check(tag, bus.probe_v, exp);
    endtask

    task automatic model_chk_all(input string tag);
        for (int k = 0; k < N; k++) probe_chk(tag, k, to18(mv[k]));
    endtask

    // One sweep; optionally a cfg write during neuron mk's update cycle and
    // step_start pokes during SWEEP and DONE.
    task automatic sweep(input int mk, input int msel, input logic [W-1:0] mdata, input bit poke);
        int n_busy, n_done, done_at, id_err;
        logic [N-1:0] got_spk;
        model_sweep(mk, msel, mdata);
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        n_busy = 0; n_done = 0; done_at = -1; id_err = 0; got_spk = '0;
        for (int c = 0; c < N + 4; c++) begin
            if (bus.busy) begin
                n_busy++;
                if (bus.cur_id !== c[IDW-1:0]) id_err++;
            end else if (bus.cur_id !== '0) begin
                id_err++;
            end
            if (bus.step_done) begin
                n_done++;
                done_at = c;
                got_spk = bus.spike_vec;
            end
            if (c == mk) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = mk[IDW-1:0];
                bus.cfg_sel  = msel[1:0];
                bus.cfg_data = mdata;
            end
            if (poke && (c == 1 || c == N)) bus.step_start = 1'b1;
            tick();
            bus.cfg_we     = 1'b0;
            bus.step_start = 1'b0;
        end
        check("busy_len", n_busy, N);
        check("done_cnt", n_done, 1);
        check("done_at", done_at, N);
        check("cur_id", id_err, 0);
        check("spike_at_done", got_spk, exp_spk);
        check("spike_hold", bus.spike_vec, exp_spk);
    endtask

    initial begin
        int spk0, mspk0, n_done, n_busy;
        rst = 1'b1;
        bus.step_start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0;
        bus.cfg_sel = '0; bus.cfg_data = '0; bus.probe_id = '0;
        for (int k = 0; k < N; k++) cur_tab[k] = '0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.step_done, 0);
        check("rst_spike", bus.spike_vec, 0);
        check("rst_cur_id", bus.cur_id, 0);
        check("rst_probe", bus.probe_v, 18'h34CCD);
        for (int k = 0; k < N; k++) probe_chk("rst_v", k, 18'h34CCD);

        // First sweep, zero current, default configuration.
        sweep(-1, 0, '0, 1'b0);
        check("sweep1_spike", bus.spike_vec, 4'b0000);
        probe_chk("v0_sweep1", 0, 18'h34DC2);
        model_chk_all("sweep1_v");

        // Forced spike on neuron 2.
        cfg_write(2, 3, 18'h08000);
        probe_chk("v2_forced", 2, 18'h08000);
        sweep(-1, 0, '0, 1'b0);
        check("spike_n2", bus.spike_vec, 4'b0100);
        probe_chk("v2_takes_c", 2, 18'h34CCD);
        model_chk_all("sweep2_v");

        // c write to neuron 3 in its own update cycle, plus ignored step_start pokes.
        cfg_write(3, 3, 18'h08000);
        sweep(3, 1, 18'h38000, 1'b1);
        check("spike_n3", bus.spike_vec, 4'b1000);
        probe_chk("v3_old_c", 3, 18'h34CCD);
        cfg_write(3, 3, 18'h08000);
        sweep(1, 3, 18'h01000, 1'b0);
        check("spike_n3_again", bus.spike_vec, 4'b1000);
        probe_chk("v1_write_wins", 1, 18'h01000);
        probe_chk("v3_new_c", 3, 18'h38000);
        model_chk_all("midcfg_v");

        // Strong drive: periodic spiking.
        for (int k = 0; k < N; k++) cur_tab[k] = 18'h0FFFF;
        spk0 = 0; mspk0 = 0;
        for (int s = 0; s < 20; s++) begin
            sweep(-1, 0, '0, 1'b0);
            if (bus.spike_vec[0]) spk0++;
            if (exp_spk[0]) mspk0++;
            probe_chk("periodic_v", s % N, to18(mv[s % N]));
        end
        check("periodic_spikes0", spk0, mspk0);

        // Drive u of neuron 0 into its positive clamp, then v into its negative clamp.
        cfg_write(0, 2, 18'h1FFFF);
        cfg_write(0, 3, 18'h08000);
        sweep(-1, 0, '0, 1'b0);
        cfg_write(0, 3, 18'h08000);
        sweep(-1, 0, '0, 1'b0);
        cur_tab[0] = '0;
        cfg_write(0, 3, '0);
        sweep(-1, 0, '0, 1'b0);
        probe_chk("v0_u_sat", 0, 18'h3F666);
        cur_tab[0] = 18'h20000;
        cfg_write(0, 3, 18'h20000);
        sweep(-1, 0, '0, 1'b0);
        probe_chk("v0_clamp", 0, 18'h20000);
        model_chk_all("clamp_v");

        // Reset during the second SWEEP cycle.
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_done = 0; n_busy = 0;
        for (int c = 0; c < N + 3; c++) begin
            if (bus.step_done) n_done++;
            if (bus.busy) n_busy++;
            tick();
        end
        check("midrst_no_done", n_done, 0);
        check("midrst_busy", n_busy, 0);
        check("midrst_spike", bus.spike_vec, 4'b0000);
        for (int k = 0; k < N; k++) probe_chk("midrst_v", k, 18'h34CCD);
        model_reset();
        for (int k = 0; k < N; k++) cur_tab[k] = '0;
        sweep(-1, 0, '0, 1'b0);
        for (int k = 0; k < N; k++) probe_chk("post_rst_v", k, 18'h34DC2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
